// File: rtl/dh_game_ctrl.sv
// Duck Hunt game sequencer: spawn, flight, hit/miss animation, round end, scoring.
// Optional DH_CTRL_SPEEDUP_EN: duck speed and flight time scale with the round number.
module dh_game_ctrl #(
   parameter int SHOTS_PER_DUCK  = 3,
   parameter int DUCKS_PER_ROUND = 10,
   parameter int PASS_HITS       = 6,
   parameter int FLIGHT_FRAMES   = 300,
   parameter int ANIM_FRAMES     = 60,
   parameter int POINTS          = 100,
   parameter int SCORE_W         = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               trigger,
   input  logic               hit,
   input  logic               duck_escaped,
   output logic               shot,
   output logic               duck_spawn,
   output logic               duck_active,
   output logic               duck_falling,
   output logic               dog_laugh,
   output logic [1:0]         shots_left,
   output logic [3:0]         ducks_hit,
   output logic [3:0]         duck_idx,
   output logic [7:0]         round,
   output logic [SCORE_W-1:0] score,
   output logic               game_over,
   output logic [2:0]         duck_speed
);
   typedef enum logic [2:0] {
      S_IDLE, S_SPAWN, S_FLIGHT, S_FALL, S_MISS, S_NEXT, S_GAME_OVER
   } state_t;

   state_t             state;
   logic               trigger_q;
   logic               hit_win;
   logic [15:0]        fcnt;
   logic [15:0]        flight_limit;
   logic               trig_edge;
   logic               timeout;
   logic               anim_done;
   logic [SCORE_W:0]   score_sum;

`ifdef DH_CTRL_SPEEDUP_EN
   localparam logic [15:0] FF_FULL = 16'(FLIGHT_FRAMES);
   localparam logic [15:0] FF_MIN  = 16'(FLIGHT_FRAMES / 4);
   logic [15:0] speedup;
   always_comb begin
      speedup      = {4'd0, round - 8'd1, 4'd0};
      flight_limit = (speedup >= FF_FULL - FF_MIN) ? FF_MIN : FF_FULL - speedup;
   end
`else
   assign flight_limit = 16'(FLIGHT_FRAMES);
`endif

   assign trig_edge = trigger & ~trigger_q;
   assign timeout   = frame_tick && (fcnt + 16'd1 >= flight_limit);
   assign anim_done = frame_tick && (fcnt + 16'd1 >= 16'(ANIM_FRAMES));
   assign score_sum = {1'b0, score} + (SCORE_W+1)'(POINTS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         trigger_q    <= 1'b0;
         hit_win      <= 1'b0;
         fcnt         <= '0;
         shot         <= 1'b0;
         duck_spawn   <= 1'b0;
         duck_active  <= 1'b0;
         duck_falling <= 1'b0;
         dog_laugh    <= 1'b0;
         shots_left   <= '0;
         ducks_hit    <= '0;
         duck_idx     <= '0;
         round        <= '0;
         score        <= '0;
         game_over    <= 1'b0;
         duck_speed   <= 3'd1;
      end else begin
         trigger_q <= trigger;
         case (state)
            S_IDLE: if (trig_edge) begin
               state      <= S_SPAWN;
               duck_spawn <= 1'b1;
               round      <= 8'd1;
               score      <= '0;
               ducks_hit  <= '0;
               duck_idx   <= '0;
            end
            S_SPAWN: begin
               state       <= S_FLIGHT;
               duck_spawn  <= 1'b0;
               duck_active <= 1'b1;
               shots_left  <= 2'(SHOTS_PER_DUCK);
               fcnt        <= '0;
               hit_win     <= 1'b0;
`ifdef DH_CTRL_SPEEDUP_EN
               duck_speed  <= (round > 8'd7) ? 3'd7 : round[2:0];
`endif
            end
            S_FLIGHT: begin
               shot    <= 1'b0;
               hit_win <= shot;
               // a hit answer outranks a same-cycle timeout or escape
               if (hit_win && hit) begin
                  state        <= S_FALL;
                  duck_active  <= 1'b0;
                  duck_falling <= 1'b1;
                  hit_win      <= 1'b0;
                  fcnt         <= '0;
                  ducks_hit    <= ducks_hit + 4'd1;
                  score        <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
               end else if ((hit_win && shots_left == 2'd0) || timeout || duck_escaped) begin
                  state       <= S_MISS;
                  duck_active <= 1'b0;
                  dog_laugh   <= 1'b1;
                  hit_win     <= 1'b0;
                  fcnt        <= '0;
               end else begin
                  if (frame_tick) fcnt <= fcnt + 16'd1;
                  // no new shot while a previous one awaits its answer
                  if (trig_edge && shots_left != 2'd0 && !shot && !hit_win) begin
                     shot       <= 1'b1;
                     shots_left <= shots_left - 2'd1;
                  end
               end
            end
            S_FALL, S_MISS: if (anim_done) begin
               state        <= S_NEXT;
               duck_falling <= 1'b0;
               dog_laugh    <= 1'b0;
            end else if (frame_tick) begin
               fcnt <= fcnt + 16'd1;
            end
            S_NEXT: begin
               if (duck_idx < 4'(DUCKS_PER_ROUND - 1)) begin
                  state      <= S_SPAWN;
                  duck_spawn <= 1'b1;
                  duck_idx   <= duck_idx + 4'd1;
               end else if (ducks_hit >= 4'(PASS_HITS)) begin
                  state      <= S_SPAWN;
                  duck_spawn <= 1'b1;
                  round      <= (round == 8'hFF) ? round : round + 8'd1;
                  ducks_hit  <= '0;
                  duck_idx   <= '0;
               end else begin
                  state     <= S_GAME_OVER;
                  game_over <= 1'b1;
               end
            end
            S_GAME_OVER: if (trig_edge) begin
               state     <= S_IDLE;
               game_over <= 1'b0;
               round     <= '0;
               score     <= '0;
               ducks_hit <= '0;
               duck_idx  <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
